// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and frame helpers for the program loader.
package prog_loader_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // A header byte of zero stands for a full-memory image.
  function automatic logic [ADDR_W:0] frame_len(input logic [DATA_W-1:0] hdr);
    logic [ADDR_W:0] len;
    if (hdr == '0) len = (ADDR_W+1)'(DEPTH);
    else           len = hdr[ADDR_W:0];
    return len;
  endfunction

  function automatic logic hdr_too_long(input logic [DATA_W-1:0] hdr);
    return hdr > DATA_W'(DEPTH);
  endfunction

endpackage

// File: rtl/prog_loader_mem.sv
// Program memory: DEPTH x DATA_W, synchronous write, combinational read.
// A same-cycle write to the read address shows the old word until the edge.
module prog_mem
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a checksummed program frame, fills program memory,
// and holds the CPU in reset until a good image has been loaded.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [ADDR_W:0]   n_len, n_len_nxt;
  logic [DATA_W-1:0] sum, sum_nxt;
  logic              xfer;
  logic              we;

  assign rx_ready_o = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  assign cpu_rst_o  = (state != S_RUN);
  assign done_o     = (state == S_RUN);
  assign err_o      = (state == S_ERR);
  assign xfer       = rx_valid_i && rx_ready_o;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      n_len <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n_len <= n_len_nxt;
      sum   <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_len_nxt = n_len;
    sum_nxt   = sum;
    we        = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req_i) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          if (hdr_too_long(rx_data_i)) begin
            state_nxt = S_ERR;
          end else begin
            n_len_nxt = frame_len(rx_data_i);
            cnt_nxt   = '0;
            sum_nxt   = rx_data_i;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          we      = 1'b1;
          sum_nxt = sum + rx_data_i;
          cnt_nxt = cnt + CNT_ONE;
          if (cnt == n_len - CNT_ONE) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) state_nxt = (rx_data_i == sum) ? S_RUN : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  prog_mem u_mem (
    .clk_i (clk_i),
    .we    (we),
    .waddr (cnt[ADDR_W-1:0]),
    .wdata (rx_data_i),
    .raddr (fetch_addr_i),
    .rdata (fetch_data_o)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a frame-level reference model.
module tb_prog_loader;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [4:0] fetch_addr = '0;
  logic [7:0] fetch_data;
  logic       cpu_rst, done, err;

  int checks = 0;
  int errors = 0;
  bit hold_fetch = 1'b0;

  prog_loader dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .load_req_i   (load_req),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .fetch_addr_i (fetch_addr),
    .fetch_data_o (fetch_data),
    .cpu_rst_o    (cpu_rst),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: loading is one phase; the frame is judged from the bytes collected.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_ERR = 3;
  int         m_phase = P_IDLE;
  logic [7:0] m_q[$];
  logic [7:0] m_mem [32];
  bit         m_known [32];

  always @(posedge clk_i or posedge reset) begin
    if (reset) begin
      m_phase = P_IDLE;
      m_q.delete();
    end else if (m_phase == P_LOAD) begin
      if (rx_valid) begin
        int n, sz, s;
        m_q.push_back(rx_data);
        sz = m_q.size();
        n  = (m_q[0] == 0) ? 32 : int'(m_q[0]);
        if (sz == 1 && m_q[0] > 32) begin
          m_phase = P_ERR;
        end else if (sz >= 2 && sz <= n + 1) begin
          m_mem[sz-2]   = rx_data;
          m_known[sz-2] = 1'b1;
        end else if (sz == n + 2) begin
          s = 0;
          for (int i = 0; i <= n; i++) s += int'(m_q[i]);
          m_phase = (int'(rx_data) == (s % 256)) ? P_RUN : P_ERR;
        end
      end
    end else if (load_req) begin
      m_phase = P_LOAD;
      m_q.delete();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset) begin
      check("cpu_rst", 32'(cpu_rst), 32'(m_phase != P_RUN));
      check("rx_ready", 32'(rx_ready), 32'(m_phase == P_LOAD));
      check("done", 32'(done), 32'(m_phase == P_RUN));
      check("err", 32'(err), 32'(m_phase == P_ERR));
      if (m_known[fetch_addr]) check("fetch", 32'(fetch_data), 32'(m_mem[fetch_addr]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (!hold_fetch) fetch_addr = 5'($urandom_range(31));
    end
  endtask

  task automatic send(input logic [7:0] b, input bit noise);
    int g;
    g = noise ? int'($urandom_range(0, 2)) : 0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (g > 0) cyc(g);
    rx_data  = b;
    rx_valid = 1'b1;
    if (noise) load_req = 1'($urandom_range(1));
    cyc(1);
    rx_valid = 1'b0;
    load_req = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic load();
    load_req = 1'b1;
    cyc(1);
    load_req = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [7:0] exp, input string name);
    hold_fetch = 1'b1;
    fetch_addr = a;
    #1;
    check(name, 32'(fetch_data), 32'(exp));
    hold_fetch = 1'b0;
  endtask

  task automatic good_3(input bit bad);
    load();
    send(8'd3, 1'b0);
    send(8'h21, 1'b0);
    send(8'h42, 1'b0);
    send(8'hE0, 1'b0);
    check("cpu_rst_before_chk", 32'(cpu_rst), 32'd1);
    send(bad ? 8'h47 : 8'h46, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    // 1: reset state, idle until requested
    #2;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(4);
    check("idle_hold_ready", 32'(rx_ready), 32'd0);

    // 2: short good image
    good_3(1'b0);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_done", 32'(done), 32'd1);
    check("model_run", 32'(m_phase), 32'(P_RUN));
    peek(5'd0, 8'h21, "fetch0");
    peek(5'd1, 8'h42, "fetch1");
    peek(5'd2, 8'hE0, "fetch2");
    cyc(3);

    // 3: bad checksum, then recover
    good_3(1'b1);
    check("bad_err", 32'(err), 32'd1);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("model_err", 32'(m_phase), 32'(P_ERR));
    good_3(1'b0);
    check("recover_err", 32'(err), 32'd0);
    check("recover_done", 32'(done), 32'd1);

    // 4: full-depth image
    load();
    send(8'd0, 1'b0);
    for (int i = 1; i <= 32; i++) send(8'(i), 1'b1);
    send(8'h10, 1'b0);
    check("full_done", 32'(done), 32'd1);
    peek(5'd31, 8'h20, "fetch31");

    // 5: oversize header rejected without writes
    load();
    send(8'h21, 1'b0);
    check("oversize_err", 32'(err), 32'd1);
    cyc(2);
    peek(5'd0, 8'h01, "oversize_nowrite");

    // 6: reset mid-frame, with stall gaps before it
    load();
    send(8'd5, 1'b0);
    send(8'hAA, 1'b1);
    cyc(3);
    send(8'hBB, 1'b0);
    cyc(2);
    #3 reset = 1'b1;
    #1;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_ready", 32'(rx_ready), 32'd0);
    peek(5'd1, 8'hBB, "partial_write");
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // random frames
    for (int f = 0; f < 60; f++) begin
      logic [7:0] l, b, s;
      int n;
      l = ($urandom_range(5) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, 32));
      n = (l == 0) ? 32 : int'(l);
      load();
      send(l, 1'b1);
      if (l <= 32) begin
        s = l;
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          s = s + b;
          send(b, 1'b1);
        end
        if ($urandom_range(3) == 0) s = s + 8'($urandom_range(1, 255));
        send(s, 1'b1);
      end
      cyc($urandom_range(0, 3));
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
